// File: rtl/memory_access_sequencer.sv
// Byte-serial sequencer between the control unit and a byte-wide single-port RAM.
// Handles user/privileged stack push/pop and 1/2/4-byte loads/stores at descending addresses.
module memory_access_sequencer #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned USER_BASE = 32,
    parameter int unsigned USER_TOP  = 36,
    parameter int unsigned PRIV_BASE = 38,
    parameter int unsigned PRIV_TOP  = 42
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic              req_write,
    input  logic              req_mode,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [31:0]       user_sp,
    output logic [31:0]       priv_sp
);

    localparam logic [31:0] SpEmpty = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_t;

    state_t            r_state;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_fault;
    logic [31:0]       r_user_sp;
    logic [31:0]       r_priv_sp;
    logic [23:0]       r_wdata;
    logic [31:0]       r_rbuf;
    logic [31:0]       r_sp_new;
    logic              r_mode;
    logic              r_stack;
    logic              r_write;
    logic [1:0]        r_k;
    logic [1:0]        r_last;

    logic [31:0]       w_sp;
    logic [31:0]       w_sp_dec;
    logic [31:0]       w_base;
    logic [31:0]       w_top;
    logic [31:0]       w_sp_new;
    logic [ADDR_W-1:0] w_first;
    logic [1:0]        w_last;
    logic              w_fault;
    logic              w_noop;
    logic              w_stack;
    logic              w_write;
    logic [1:0]        w_k_prev;
    logic [31:0]       w_rbuf_fin;

    assign w_sp     = req_mode ? r_priv_sp : r_user_sp;
    assign w_sp_dec = w_sp - 32'd1;
    assign w_base   = req_mode ? 32'(PRIV_BASE) : 32'(USER_BASE);
    assign w_top    = req_mode ? 32'(PRIV_TOP) : 32'(USER_TOP);
    assign w_k_prev = r_k - 2'd1;

    // Request decode: first address, byte count and stack bounds check
    always_comb begin
        w_fault  = 1'b0;
        w_noop   = 1'b0;
        w_stack  = 1'b0;
        w_write  = req_write;
        w_last   = 2'd0;
        w_first  = req_addr[ADDR_W-1:0];
        w_sp_new = w_sp;
        unique case (req_op)
            3'd1: begin
                w_stack = 1'b1;
                w_write = 1'b1;
                if (w_sp == SpEmpty) begin
                    w_first  = w_top[ADDR_W-1:0];
                    w_sp_new = w_top;
                end else if (w_sp > w_base && w_sp <= w_top) begin
                    w_first  = w_sp_dec[ADDR_W-1:0];
                    w_sp_new = w_sp_dec;
                end else begin
                    w_fault = 1'b1;
                end
            end
            3'd2: begin
                w_stack = 1'b1;
                w_write = 1'b0;
                if (w_sp >= w_base && w_sp < w_top) begin
                    w_first  = w_sp[ADDR_W-1:0];
                    w_sp_new = w_sp + 32'd1;
                end else if (w_sp == w_top) begin
                    w_first  = w_top[ADDR_W-1:0];
                    w_sp_new = SpEmpty;
                end else begin
                    w_fault = 1'b1;
                end
            end
            3'd3:    w_last = 2'd0;
            3'd4:    w_last = 2'd1;
            3'd5:    w_last = 2'd3;
            default: w_noop = 1'b1;
        endcase
    end

    always_comb begin
        w_rbuf_fin = r_rbuf;
        w_rbuf_fin[{r_k, 3'b000} +: 8] = mem_rdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_fault <= 1'b0;
            r_user_sp   <= SpEmpty;
            r_priv_sp   <= SpEmpty;
            r_wdata     <= 24'h0;
            r_rbuf      <= 32'h0;
            r_sp_new    <= 32'h0;
            r_mode      <= 1'b0;
            r_stack     <= 1'b0;
            r_write     <= 1'b0;
            r_k         <= 2'd0;
            r_last      <= 2'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_rbuf      <= 32'h0;
                        r_sp_new    <= w_sp_new;
                        r_mode      <= req_mode;
                        r_stack     <= w_stack;
                        r_write     <= w_write;
                        if (w_fault || w_noop) begin
                            r_state     <= StDone;
                            r_rsp_valid <= 1'b1;
                            r_rsp_fault <= w_fault;
                            if (w_fault && req_op == 3'd2) begin
                                r_rsp_rdata <= 32'h0;
                            end
                        end else begin
                            r_state     <= StAccess;
                            r_mem_addr  <= w_first;
                            r_mem_we    <= w_write;
                            r_mem_wdata <= req_wdata[7:0];
                            r_wdata     <= req_wdata[31:8];
                            r_k         <= 2'd0;
                            r_last      <= w_last;
                        end
                    end
                end
                StAccess: begin
                    // Data for the byte issued last cycle is on mem_rdata now
                    if (!r_write && r_k != 2'd0) begin
                        r_rbuf[{w_k_prev, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (r_k != r_last) begin
                        r_k         <= r_k + 2'd1;
                        r_mem_addr  <= r_mem_addr - ADDR_W'(1);
                        r_mem_wdata <= r_wdata[7:0];
                        r_wdata     <= {8'h00, r_wdata[23:8]};
                    end else begin
                        r_mem_we <= 1'b0;
                        if (r_write) begin
                            r_state     <= StDone;
                            r_rsp_valid <= 1'b1;
                            if (r_stack && r_mode) r_priv_sp <= r_sp_new;
                            if (r_stack && !r_mode) r_user_sp <= r_sp_new;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    r_state     <= StDone;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_rbuf_fin;
                    if (r_stack && r_mode) r_priv_sp <= r_sp_new;
                    if (r_stack && !r_mode) r_user_sp <= r_sp_new;
                end
                StDone: begin
                    r_state     <= StIdle;
                    r_rsp_valid <= 1'b0;
                    r_rsp_fault <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;
    assign user_sp   = r_user_sp;
    assign priv_sp   = r_priv_sp;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed self-checking bench for memory_access_sequencer with a byte-wide synchronous RAM model.
module tb_memory_access_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic        req_write = 1'b0;
    logic        req_mode = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] user_sp;
    logic [31:0] priv_sp;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    logic [7:0] ram [0:2047];

    memory_access_sequencer #(
        .ADDR_W(11), .USER_BASE(32), .USER_TOP(36), .PRIV_BASE(38), .PRIV_TOP(42)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .user_sp(user_sp), .priv_sp(priv_sp)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Present a request once ready; returns just after the accept edge (cycle 0)
    task automatic send(input logic [2:0] op, input logic wr, input logic md,
                        input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (req_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL send_ready_timeout req_ready=%b required=1", req_ready);
        end
        req_op = op; req_write = wr; req_mode = md; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b req=0", rsp_valid); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b req=0", mem_we); end
        checks++; if (mem_addr !== 11'h0) begin failures++; $display("FAIL rst_mem_addr got=%h req=0", mem_addr); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h req=0", rsp_rdata); end
        checks++; if (user_sp !== 32'hFFFFFFFF) begin failures++; $display("FAIL rst_user_sp got=%h req=ffffffff", user_sp); end
        checks++; if (priv_sp !== 32'hFFFFFFFF) begin failures++; $display("FAIL rst_priv_sp got=%h req=ffffffff", priv_sp); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b req=1", req_ready); end
    endtask

    task automatic test_push_first;
        send(3'd1, 1'b0, 1'b0, 32'h0, 32'h0000_00A5);
        @(negedge clock);
        checks++; if (mem_addr !== 11'd36) begin failures++; $display("FAIL push1_addr got=%0d req=36", mem_addr); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL push1_we got=%b req=1", mem_we); end
        checks++; if (mem_wdata !== 8'hA5) begin failures++; $display("FAIL push1_wdata got=%h req=a5", mem_wdata); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL push1_early_rsp got=%b req=0", rsp_valid); end
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) begin failures++; $display("FAIL push1_rsp got=%b/%b req=1/0", rsp_valid, rsp_fault); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL push1_we_done got=%b req=0", mem_we); end
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL push1_ready got=%b req=1", req_ready); end
        checks++; if (user_sp !== 32'd36) begin failures++; $display("FAIL push1_user_sp got=%h req=24", user_sp); end
        checks++; if (priv_sp !== 32'hFFFFFFFF) begin failures++; $display("FAIL push1_priv_sp got=%h req=ffffffff", priv_sp); end
    endtask

    task automatic test_push_fill;
        int wc;
        for (int i = 0; i < 4; i++) begin
            send(3'd1, 1'b0, 1'b0, 32'h0, 32'h10 + i);
            @(negedge clock);
            checks++; if (mem_addr !== 11'(35 - i) || mem_we !== 1'b1) begin failures++; $display("FAIL fill%0d_addr got=%0d/%b req=%0d/1", i, mem_addr, mem_we, 35 - i); end
            @(negedge clock);
            checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) begin failures++; $display("FAIL fill%0d_rsp got=%b/%b req=1/0", i, rsp_valid, rsp_fault); end
        end
        @(negedge clock);
        checks++; if (user_sp !== 32'd32) begin failures++; $display("FAIL fill_user_sp got=%h req=20", user_sp); end
        wc = wr_count;
        send(3'd1, 1'b0, 1'b0, 32'h0, 32'hEE);
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1) begin failures++; $display("FAIL overflow_rsp got=%b/%b req=1/1", rsp_valid, rsp_fault); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL overflow_we got=%b req=0", mem_we); end
        @(negedge clock);
        checks++; if (wr_count !== wc) begin failures++; $display("FAIL overflow_writes got=%0d req=%0d", wr_count, wc); end
        checks++; if (user_sp !== 32'd32) begin failures++; $display("FAIL overflow_sp got=%h req=20", user_sp); end
    endtask

    task automatic test_pop;
        logic [10:0] ea [0:4];
        logic [7:0]  ed [0:4];
        logic [31:0] es [0:4];
        ea = '{11'd32, 11'd33, 11'd34, 11'd35, 11'd36};
        ed = '{8'h13, 8'h12, 8'h11, 8'h10, 8'hA5};
        es = '{32'd33, 32'd34, 32'd35, 32'd36, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            send(3'd2, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clock);
            checks++; if (mem_addr !== ea[i] || mem_we !== 1'b0) begin failures++; $display("FAIL pop%0d_addr got=%0d/%b req=%0d/0", i, mem_addr, mem_we, ea[i]); end
            @(negedge clock);
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL pop%0d_wait got=%b req=0", i, rsp_valid); end
            @(negedge clock);
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== {24'h0, ed[i]}) begin failures++; $display("FAIL pop%0d_data got=%b/%h req=1/%h", i, rsp_valid, rsp_rdata, ed[i]); end
            @(negedge clock);
            checks++; if (user_sp !== es[i]) begin failures++; $display("FAIL pop%0d_sp got=%h req=%h", i, user_sp, es[i]); end
        end
        send(3'd2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL underflow got=%b/%b/%h req=1/1/0", rsp_valid, rsp_fault, rsp_rdata); end
    endtask

    task automatic test_priv_stack;
        send(3'd1, 1'b0, 1'b1, 32'h0, 32'h0000_3C5A);
        @(negedge clock);
        checks++; if (mem_addr !== 11'd42 || mem_wdata !== 8'h5A) begin failures++; $display("FAIL priv_push got=%0d/%h req=42/5a", mem_addr, mem_wdata); end
        repeat (2) @(negedge clock);
        checks++; if (priv_sp !== 32'd42 || user_sp !== 32'hFFFFFFFF) begin failures++; $display("FAIL priv_sps got=%h/%h req=2a/ffffffff", priv_sp, user_sp); end
        send(3'd2, 1'b0, 1'b1, 32'h0, 32'h0);
        repeat (3) @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A) begin failures++; $display("FAIL priv_pop got=%b/%h req=1/5a", rsp_valid, rsp_rdata); end
        @(negedge clock);
        checks++; if (priv_sp !== 32'hFFFFFFFF) begin failures++; $display("FAIL priv_pop_sp got=%h req=ffffffff", priv_sp); end
    endtask

    task automatic test_word;
        logic [7:0] eb [0:3];
        int c;
        eb = '{8'h44, 8'h33, 8'h22, 8'h11};
        send(3'd5, 1'b1, 1'b0, 32'h205, 32'h1122_3344);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++; if (mem_addr !== 11'(32'h205 - k) || mem_we !== 1'b1 || mem_wdata !== eb[k]) begin failures++; $display("FAIL wst%0d got=%h/%b/%h req=%h/1/%h", k, mem_addr, mem_we, mem_wdata, 32'h205 - k, eb[k]); end
        end
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL wst_done got=%b/%b req=1/0", rsp_valid, mem_we); end
        send(3'd5, 1'b0, 1'b0, 32'h205, 32'h0);
        wait_rsp(c);
        checks++; if (c !== 6) begin failures++; $display("FAIL wld_latency got=%0d req=6", c); end
        checks++; if (rsp_rdata !== 32'h1122_3344) begin failures++; $display("FAIL wld_data got=%h req=11223344", rsp_rdata); end
    endtask

    task automatic test_half_wrap;
        int c;
        ram[0] = 8'hBE;
        ram[11'h7FF] = 8'hEF;
        send(3'd4, 1'b0, 1'b0, 32'hFFFF_F800, 32'h0);
        @(negedge clock);
        checks++; if (mem_addr !== 11'h000) begin failures++; $display("FAIL half_a0 got=%h req=000", mem_addr); end
        @(negedge clock);
        checks++; if (mem_addr !== 11'h7FF) begin failures++; $display("FAIL half_a1 got=%h req=7ff", mem_addr); end
        wait_rsp(c);
        checks++; if (c !== 2) begin failures++; $display("FAIL half_latency got=%0d req=4", c + 2); end
        checks++; if (rsp_rdata !== 32'h0000_EFBE) begin failures++; $display("FAIL half_data got=%h req=0000efbe", rsp_rdata); end
    endtask

    task automatic test_noop;
        int wc;
        wc = wr_count;
        send(3'd0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL noop_rsp got=%b/%b/%b req=1/0/0", rsp_valid, rsp_fault, mem_we); end
        checks++; if (rsp_rdata !== 32'h0000_EFBE) begin failures++; $display("FAIL noop_hold got=%h req=0000efbe", rsp_rdata); end
        @(negedge clock);
        checks++; if (wr_count !== wc) begin failures++; $display("FAIL noop_writes got=%0d req=%0d", wr_count, wc); end
    endtask

    task automatic test_reset_mid;
        int wc;
        logic seen;
        send(3'd5, 1'b1, 1'b0, 32'h100, 32'hAABB_CCDD);
        @(negedge clock);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rmid_c1_we got=%b req=1", mem_we); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got=%b/%b req=0/0", mem_we, rsp_valid); end
        reset = 1'b1;
        wc = wr_count;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_rsp got=%b req=0", seen); end
        checks++; if (wr_count !== wc) begin failures++; $display("FAIL rmid_writes got=%0d req=%0d", wr_count, wc); end
        checks++; if (ram[11'hFF] !== 8'hCC || ram[11'hFE] !== 8'h00) begin failures++; $display("FAIL rmid_ram got=%h/%h req=cc/00", ram[11'hFF], ram[11'hFE]); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b req=1", req_ready); end
        checks++; if (user_sp !== 32'hFFFFFFFF || priv_sp !== 32'hFFFFFFFF) begin failures++; $display("FAIL rmid_sps got=%h/%h req=ffffffff", user_sp, priv_sp); end
        // Push aborted before its commit edge must leave the SP empty
        send(3'd1, 1'b0, 1'b0, 32'h0, 32'h77);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (user_sp !== 32'hFFFFFFFF || rsp_valid !== 1'b0) begin failures++; $display("FAIL rpush_abort got=%h/%b req=ffffffff/0", user_sp, rsp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        test_reset;
        test_push_first;
        test_push_fill;
        test_pop;
        test_priv_stack;
        test_word;
        test_half_wrap;
        test_noop;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
